mcu_sequencer: RTL and testbench

MCU_SEQUENCER -- requirements
Module: mcu_sequencer

---
 rtl/sys_defs.sv | 22 ++
 rtl/wait_timer.sv | 29 ++
 rtl/mcu_sequencer.sv | 157 +++++++++++++++
 tb/tb_mcu_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared types for the MCU sequencer: channel tags, sequencer states and the 8x8 block payload.
package sys_defs;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } ch_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_Y  = 3'd1,
    ISSUE_CB = 3'd2,
    ISSUE_CR = 3'd3,
    WAIT_BUF = 3'd4,
    HOLD     = 3'd5
  } state_e;

  // 8 rows x 8 columns x 8-bit samples
  typedef logic [7:0][7:0][7:0] block_t;

endpackage

// File: rtl/wait_timer.sv
// Cycle counter for the WAIT_BUF abort window; expired marks the last permitted waiting cycle.
module wait_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mcu_sequencer.sv
// Steps Y/Cb/Cr blocks of each MCU into the supersample path, then waits for the
// channel buffer to assemble the MCU and hands it to the sink.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no frame; waiting for start
// ISSUE_Y  | accepting the luma block of the current MCU
// ISSUE_CB | accepting the Cb block
// ISSUE_CR | accepting the Cr block
// WAIT_BUF | all three issued; waiting for buffer, bounded by TIMEOUT
// HOLD     | MCU presented to sink; upstream stalled until mcu_ready
module mcu_sequencer
  import sys_defs::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] mcu_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_ch,
  input  block_t           in_block,
  output logic             ss_valid,
  output logic [1:0]       ss_ch,
  output block_t           ss_block,
  input  logic             buf_valid,
  output logic             mcu_valid,
  input  logic             mcu_ready,
  output logic [CNT_W-1:0] mcu_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             err_order,
  output logic             err_timeout
);

  state_e           state;
  ch_e              exp_ch;
  logic [CNT_W-1:0] remaining;
  logic             empty_done;
  logic             timer_expired;
  logic             accept;
  logic             last_mcu;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != WAIT_BUF),
    .enable  (state == WAIT_BUF),
    .expired (timer_expired)
  );

  always_comb begin
    exp_ch = CH_Y;
    case (state)
      ISSUE_CB: exp_ch = CH_CB;
      ISSUE_CR: exp_ch = CH_CR;
      default:  exp_ch = CH_Y;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign last_mcu = (remaining == CNT_W'(1));

  // The final hand-off is flagged in the same cycle the sink consumes the MCU.
  assign frame_done = empty_done || ((state == HOLD) && mcu_ready && last_mcu);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      ss_valid    <= 1'b0;
      ss_ch       <= 2'd0;
      ss_block    <= '0;
      mcu_valid   <= 1'b0;
      mcu_idx     <= '0;
      remaining   <= '0;
      busy        <= 1'b0;
      empty_done  <= 1'b0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ss_valid   <= 1'b0;
      empty_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mcu_count != '0) begin
              state       <= ISSUE_Y;
              in_ready    <= 1'b1;
              busy        <= 1'b1;
              remaining   <= mcu_count;
              mcu_idx     <= '0;
              err_order   <= 1'b0;
              err_timeout <= 1'b0;
            end else begin
              empty_done <= 1'b1;
            end
          end
        end
        ISSUE_Y, ISSUE_CB, ISSUE_CR: begin
          if (accept) begin
            if (in_ch == exp_ch) begin
              ss_valid <= 1'b1;
              ss_ch    <= in_ch;
              ss_block <= in_block;
              if (state == ISSUE_Y) begin
                state <= ISSUE_CB;
              end else if (state == ISSUE_CB) begin
                state <= ISSUE_CR;
              end else begin
                state    <= WAIT_BUF;
                in_ready <= 1'b0;
              end
            end else begin
              // misordered block is dropped; keep waiting for the expected tag
              err_order <= 1'b1;
            end
          end
        end
        WAIT_BUF: begin
          if (buf_valid) begin
            state     <= HOLD;
            mcu_valid <= 1'b1;
          end else if (timer_expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
          end
        end
        HOLD: begin
          if (mcu_ready) begin
            mcu_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            if (last_mcu) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= ISSUE_Y;
              in_ready <= 1'b1;
              mcu_idx  <= mcu_idx + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          mcu_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Randomized directed bench for mcu_sequencer against an MCU-level model of the issue/hand-off rules.
module tb_mcu_sequencer;
  import sys_defs::*;

  localparam int TMO = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] mcu_count = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_ch = 2'd0;
  block_t        in_block = '0;
  logic          buf_valid = 1'b0;
  logic          mcu_ready = 1'b0;

  logic          in_ready, ss_valid, mcu_valid, busy, frame_done, err_order, err_timeout;
  logic [1:0]    ss_ch;
  block_t        ss_block;
  logic [CW-1:0] mcu_idx;

  mcu_sequencer #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mcu_count   (mcu_count),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_block    (in_block),
    .ss_valid    (ss_valid),
    .ss_ch       (ss_ch),
    .ss_block    (ss_block),
    .buf_valid   (buf_valid),
    .mcu_valid   (mcu_valid),
    .mcu_ready   (mcu_ready),
    .mcu_idx     (mcu_idx),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_order   (err_order),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int           n_pass = 0;
  int           n_total = 0;
  int           n_strobe = 0;
  int           n_done = 0;
  logic [513:0] act_q[$];
  logic [513:0] exp_q[$];
  int           script_q[$];
  bit           exp_err;

  // Observe outputs mid-way between the driving negedge and the next active edge.
  always begin
    @(negedge clk);
    #3;
    if (ss_valid === 1'b1) begin
      act_q.push_back({ss_ch, ss_block});
      n_strobe++;
    end
    if (frame_done === 1'b1) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic block_t rand_block();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One MCU: offer blocks until Y, Cb, Cr were each accepted in order, then
  // release the buffer after d waiting cycles (d<0: never) and stall the sink r cycles.
  task automatic run_mcu(input int m, input bit last, input int bad_pct, input int d, input int r);
    int exp_c = 0;
    while (exp_c < 3) begin
      logic [1:0] ch;
      block_t     b;
      int         n;
      n = 0;
      b = rand_block();
      if (script_q.size() > 0) ch = 2'(script_q.pop_front());
      else if (int'($urandom_range(99)) < bad_pct) ch = 2'((exp_c + 1 + int'($urandom_range(2))) % 4);
      else ch = 2'(exp_c);
      in_valid  = 1'b1;
      in_ch     = ch;
      in_block  = b;
      buf_valid = 1'($urandom);
      mcu_ready = 1'($urandom);
      start     = ($urandom_range(3) == 0);
      mcu_count = CW'($urandom_range(3));
      while (in_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n == 20) chk("in_ready_wait", in_ready, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      buf_valid = 1'b0;
      mcu_ready = 1'b0;
      start     = 1'b0;
      chk("ss_valid", ss_valid, (ch == 2'(exp_c)));
      if (ch == 2'(exp_c)) begin
        exp_q.push_back({ch, b});
        exp_c++;
      end else begin
        exp_err = 1'b1;
      end
      chk("err_order", err_order, exp_err);
      chk("mcu_valid_issue", mcu_valid, 0);
    end

    if (d < 0) begin
      int n = 0;
      while (busy === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("timeout_cycles", n, TMO);
      chk("err_timeout", err_timeout, 1);
      chk("timeout_outputs", {in_ready, mcu_valid, busy}, 0);
      return;
    end

    repeat (d) begin
      chk("wait_state", {busy, mcu_valid, in_ready}, 3'b100);
      @(negedge clk);
    end
    buf_valid = 1'b1;
    @(negedge clk);
    buf_valid = 1'b0;
    chk("mcu_valid", mcu_valid, 1);
    chk("mcu_idx", mcu_idx, m);
    chk("err_timeout_clear", err_timeout, 0);

    repeat (r) begin
      in_valid  = 1'($urandom);
      in_ch     = 2'($urandom);
      in_block  = rand_block();
      buf_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_state", {mcu_valid, in_ready, ss_valid}, 3'b100);
    end
    in_valid  = 1'b0;
    buf_valid = 1'b0;
    mcu_ready = 1'b1;
    #1;
    chk("frame_done_pulse", frame_done, last);
    @(negedge clk);
    mcu_ready = 1'b0;
    chk("after_hold", {mcu_valid, busy, in_ready}, {1'b0, !last, !last});
    if (last) chk("frame_done_end", frame_done, 0);
  endtask

  // d_fix: -2 random release delay, -1 buffer never reports; r_fix: -1 random stall.
  task automatic run_frame(input int cnt, input int bad_pct, input int d_fix, input int r_fix);
    int done0 = n_done;
    exp_err = 1'b0;
    act_q.delete();
    exp_q.delete();
    start     = 1'b1;
    mcu_count = CW'(cnt);
    @(negedge clk);
    start = 1'b0;
    chk("start_state", {busy, in_ready, err_order, err_timeout}, 4'b1100);
    chk("start_idx", mcu_idx, 0);
    for (int m = 0; m < cnt; m++) begin
      int d;
      int r;
      d = (d_fix == -2) ? int'($urandom_range(TMO - 1)) : d_fix;
      r = (r_fix < 0) ? int'($urandom_range(4)) : r_fix;
      run_mcu(m, (m == cnt - 1), bad_pct, d, r);
      if (d < 0) break;
    end
    @(negedge clk);
    #4;
    chk("strobe_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) chk("strobe", act_q[i], exp_q[i]);
    chk("frame_done_count", n_done - done0, (d_fix == -1) ? 0 : 1);
    chk("frame_err_order", err_order, exp_err);
  endtask

  initial begin
    int s0;
    int d0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {in_ready, ss_valid, mcu_valid, busy, frame_done, err_order, err_timeout, ss_ch, mcu_idx}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", {in_ready, ss_valid, mcu_valid, busy, frame_done, err_order, err_timeout, ss_ch, mcu_idx}, 0);
    chk("post_reset_block", ss_block, 0);

    // Empty frame
    s0 = n_strobe;
    d0 = n_done;
    start     = 1'b1;
    mcu_count = '0;
    @(negedge clk);
    start = 1'b0;
    chk("empty_done", frame_done, 1);
    chk("empty_busy", {busy, in_ready}, 0);
    @(negedge clk);
    #4;
    chk("empty_done_end", frame_done, 0);
    chk("empty_done_count", n_done - d0, 1);
    chk("empty_no_strobe", n_strobe - s0, 0);

    // Two MCUs, buffer after 5 cycles, sink ready at once
    run_frame(2, 0, 5, 0);
    // Misordered tags Y, Cr, Cb, Cr
    script_q = '{0, 2, 1, 2};
    run_frame(1, 0, -2, -1);
    // Buffer never reports
    run_frame(1, 0, -1, 0);
    // Sink stalls 10 cycles per MCU
    run_frame(2, 0, 3, 10);
    // Buffer report lands on the last permitted waiting cycle
    run_frame(1, 0, TMO - 1, 0);
    for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(1, 4)), 25, -2, -1);

    // Asynchronous reset while waiting for the Cb block
    d0 = n_done;
    start     = 1'b1;
    mcu_count = CW'(3);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_block = rand_block();
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_strobe", {ss_valid, in_ready, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {in_ready, ss_valid, mcu_valid, busy, frame_done, err_order, err_timeout, ss_ch, mcu_idx}, 0);
    chk("async_reset_block", ss_block, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_idle", {busy, in_ready, mcu_valid}, 0);
    chk("reset_no_done", n_done - d0, 0);
    run_frame(2, 10, -2, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
